// File: rtl/wshb_pkg.sv
// Shared types and default sizes for the
// Wishbone multi-master arbiter.
package wshb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   localparam int DEF_NUM_M   = 2;
   localparam int DEF_DWIDTH  = 64;
   localparam int DEF_AWIDTH  = 32;
   localparam int DEF_TIMEOUT = 255;

   // Watchdog counter width; a disabled
   // watchdog still keeps a 1-bit register.
   function automatic int cnt_width(
      input int tmo
   );
      return (tmo > 0) ? $clog2(tmo + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester after
// the previous owner wins, one-hot result.
module rr_pick #(
   parameter int NUM_M = 2,
   parameter int LW    = $clog2(NUM_M)
) (
   input  logic [NUM_M-1:0] req,
   input  logic [LW-1:0]    last,
   output logic [NUM_M-1:0] gnt
);

   logic [LW-1:0] w_idx;
   logic          w_done;

   // Scan last+1 .. last+NUM_M, wrapping.
   always_comb begin
      gnt    = '0;
      w_done = 1'b0;
      w_idx  = '0;
      for (int i = 1; i <= NUM_M; i++) begin
         w_idx = LW'((int'(last) + i) % NUM_M);
         if (!w_done && req[w_idx]) begin
            gnt[w_idx] = 1'b1;
            w_done     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wshb_arbiter.sv
// N-master to 1-slave Wishbone arbiter with
// round-robin grant and stall watchdog.
module wshb_arbiter
   import wshb_pkg::*;
#(
   parameter int NUM_M    = DEF_NUM_M,
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int SELWIDTH = DWIDTH / 8,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_M-1:0]          m_cyc_i,
   input  logic [NUM_M-1:0]          m_stb_i,
   input  logic [NUM_M-1:0]          m_we_i,
   input  logic [NUM_M*AWIDTH-1:0]   m_adr_i,
   input  logic [NUM_M*DWIDTH-1:0]   m_dat_i,
   input  logic [NUM_M*SELWIDTH-1:0] m_sel_i,
   output logic [DWIDTH-1:0]         m_dat_o,
   output logic [NUM_M-1:0]          m_ack_o,
   output logic [NUM_M-1:0]          m_err_o,
   output logic [NUM_M-1:0]          m_rty_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [AWIDTH-1:0]         s_adr_o,
   output logic [DWIDTH-1:0]         s_dat_o,
   output logic [SELWIDTH-1:0]       s_sel_o,
   input  logic [DWIDTH-1:0]         s_dat_i,
   input  logic                      s_ack_i,
   input  logic                      s_err_i,
   input  logic                      s_rty_i,
   output logic [NUM_M-1:0]          gnt_o
);

   localparam int LW = $clog2(NUM_M);
   localparam int CW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] TMAX =
      CW'(TIMEOUT);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [NUM_M-1:0] r_gnt;
   logic [NUM_M-1:0] w_pick;
   logic [LW-1:0]    r_last;
   logic [LW-1:0]    w_gidx;
   logic [CW-1:0]    r_cnt;
   logic             w_gcyc;
   logic             w_gstb;
   logic             w_gwe;
   logic             w_term;
   logic             w_tmo;
   logic             w_take;
   logic             w_drop;

   rr_pick #(
      .NUM_M (NUM_M),
      .LW    (LW)
   ) u_pick (
      .req  (m_cyc_i),
      .last (r_last),
      .gnt  (w_pick)
   );

   // Granted master's control bits; r_gnt is
   // one-hot so a masked OR selects them.
   assign w_gcyc = |(r_gnt & m_cyc_i);
   assign w_gstb = |(r_gnt & m_cyc_i & m_stb_i);
   assign w_gwe  = |(r_gnt & m_we_i);

   assign w_term = s_ack_i | s_err_i | s_rty_i;

   // A real slave termination beats the
   // watchdog on the same cycle.
   assign w_tmo = (TIMEOUT > 0)
               && (r_state == ARB_BUSY)
               && w_gstb
               && !w_term
               && (r_cnt == TMAX);

   assign w_take = (r_state == ARB_IDLE)
                && (|m_cyc_i);
   assign w_drop = (r_state == ARB_BUSY)
                && !w_gcyc;

   // Encode the one-hot grant to an index.
   always_comb begin
      w_gidx = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (r_gnt[k]) begin
            w_gidx = LW'(k);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: arbitrate in IDLE, hold
   // the bus while the owner keeps cyc high.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ARB_IDLE: begin
            if (w_take) begin
               w_state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (w_drop) begin
               w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Grant and last-owner registers; master 0
   // wins first after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gnt  <= '0;
         r_last <= LW'(NUM_M - 1);
      end else if (w_take) begin
         r_gnt  <= w_pick;
      end else if (w_drop) begin
         r_gnt  <= '0;
         r_last <= w_gidx;
      end
   end

   // Stall watchdog: counts unterminated
   // strobe cycles, saturating at TMAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if ((r_state != ARB_BUSY)
                || !w_gstb
                || w_term
                || w_tmo) begin
         r_cnt <= '0;
      end else if (r_cnt != TMAX) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Slave-side request mux from the owner's
   // slice; everything quiet when idle.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      if (r_state == ARB_BUSY) begin
         s_cyc_o = w_gcyc;
         s_stb_o = w_gstb & ~w_tmo;
         s_we_o  = w_gwe;
         for (int k = 0; k < NUM_M; k++) begin
            if (r_gnt[k]) begin
               s_adr_o =
                  m_adr_i[k*AWIDTH +: AWIDTH];
               s_dat_o =
                  m_dat_i[k*DWIDTH +: DWIDTH];
               s_sel_o =
                  m_sel_i[k*SELWIDTH +: SELWIDTH];
            end
         end
      end
   end

   assign m_ack_o = r_gnt & {NUM_M{s_ack_i}};
   assign m_err_o = r_gnt
                  & {NUM_M{s_err_i | w_tmo}};
   assign m_rty_o = r_gnt & {NUM_M{s_rty_i}};
   assign m_dat_o = s_dat_i;
   assign gnt_o   = r_gnt;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Scoreboard bench for wshb_arbiter with four
// masters and an 8-cycle watchdog.
module tb_wshb_arbiter;

   localparam int NM  = 4;
   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int SW  = 8;
   localparam int TMO = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [NM-1:0]    m_we_i;
   logic [NM*AW-1:0] m_adr_i;
   logic [NM*DW-1:0] m_dat_i;
   logic [NM*SW-1:0] m_sel_i;
   logic [DW-1:0]    m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [NM-1:0]    m_rty_o;
   logic             s_cyc_o;
   logic             s_stb_o;
   logic             s_we_o;
   logic [AW-1:0]    s_adr_o;
   logic [DW-1:0]    s_dat_o;
   logic [SW-1:0]    s_sel_o;
   logic [DW-1:0]    s_dat_i;
   logic             s_ack_i;
   logic             s_err_i;
   logic             s_rty_i;
   logic [NM-1:0]    gnt_o;

   always #5 clk = ~clk;

   wshb_arbiter #(
      .NUM_M    (NM),
      .DWIDTH   (DW),
      .AWIDTH   (AW),
      .SELWIDTH (SW),
      .TIMEOUT  (TMO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_adr_i (m_adr_i),
      .m_dat_i (m_dat_i),
      .m_sel_i (m_sel_i),
      .m_dat_o (m_dat_o),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .m_rty_o (m_rty_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_sel_o (s_sel_o),
      .s_dat_i (s_dat_i),
      .s_ack_i (s_ack_i),
      .s_err_i (s_err_i),
      .s_rty_i (s_rty_i),
      .gnt_o   (gnt_o)
   );

   typedef struct {
      logic [NM-1:0] ack;
      logic [NM-1:0] err;
      logic [NM-1:0] rty;
      logic [DW-1:0] dat;
   } term_t;

   term_t         tq[$];
   logic [NM-1:0] gq[$];
   int            checks = 0;
   int            errors = 0;
   logic [NM-1:0] prev_gnt = '0;
   term_t         mt;
   logic [NM-1:0] mg;
   int            order[5] = '{0, 1, 2, 3, 0};
   int            e;
   logic [NM-1:0] oh;

   function automatic logic [AW-1:0] adr_of(
      input int k
   );
      return 32'h1000_0000 + 32'(k) * 32'h10;
   endfunction

   function automatic logic [DW-1:0] dat_of(
      input int k
   );
      return 64'hD0D0_0000_0000_0000
           | 64'(k);
   endfunction

   task automatic chk(
      input string       nm,
      input logic [63:0] act,
      input logic [63:0] exp
   );
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setm(
      input logic [1:0] k,
      input logic       v
   );
      m_cyc_i[k] = v;
      m_stb_i[k] = v;
   endtask

   task automatic pt(
      input logic [NM-1:0] a,
      input logic [NM-1:0] er,
      input logic [NM-1:0] r,
      input logic [DW-1:0] d
   );
      tq.push_back('{ack: a, err: er,
                     rty: r, dat: d});
   endtask

   // Monitor: pops expected terminations and
   // grant changes as the DUT presents them.
   always @(negedge clk) begin
      if (|m_ack_o || |m_err_o || |m_rty_o) begin
         if (tq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL term_unexp ack=%b err=%b rty=%b want=none",
                     m_ack_o, m_err_o, m_rty_o);
         end else begin
            mt = tq.pop_front();
            chk("term_ack", 64'(m_ack_o), 64'(mt.ack));
            chk("term_err", 64'(m_err_o), 64'(mt.err));
            chk("term_rty", 64'(m_rty_o), 64'(mt.rty));
            chk("term_dat", m_dat_o, mt.dat);
         end
      end
      if (gnt_o !== prev_gnt && gnt_o !== '0) begin
         if (gq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexp got=%b want=none",
                     gnt_o);
         end else begin
            mg = gq.pop_front();
            chk("grant", 64'(gnt_o), 64'(mg));
         end
      end
      prev_gnt = gnt_o;
   end

   initial begin
      #200000;
      $display("FAIL watchdog sim_time_expired");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst_n   = 1'b0;
      m_cyc_i = '0;
      m_stb_i = '0;
      m_we_i  = '0;
      m_adr_i = {adr_of(3), adr_of(2),
                 adr_of(1), adr_of(0)};
      m_dat_i = {dat_of(3), dat_of(2),
                 dat_of(1), dat_of(0)};
      m_sel_i = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
      s_dat_i = '0;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_rty_i = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 64'(gnt_o), 64'd0);
      chk("rst_cyc", 64'(s_cyc_o), 64'd0);
      chk("rst_stb", 64'(s_stb_o), 64'd0);
      chk("rst_adr", 64'(s_adr_o), 64'd0);
      rst_n = 1'b1;
      tick();

      // both request: m0 first, dead cycle, m1
      m_cyc_i = 4'b0011;
      m_stb_i = 4'b0011;
      gq.push_back(4'b0001);
      tick();
      chk("A_cyc", 64'(s_cyc_o), 64'd1);
      chk("A_adr0", 64'(s_adr_o), 64'(adr_of(0)));
      chk("A_dat0", s_dat_o, dat_of(0));
      chk("A_sel0", 64'(s_sel_o), 64'hF0);
      s_ack_i = 1'b1;
      s_dat_i = 64'h1111_2222_3333_4444;
      pt(4'b0001, 4'b0, 4'b0, s_dat_i);
      tick();
      s_ack_i = 1'b0;
      setm(2'd0, 1'b0);
      gq.push_back(4'b0010);
      tick();
      chk("A_dead_gnt", 64'(gnt_o), 64'd0);
      chk("A_dead_cyc", 64'(s_cyc_o), 64'd0);
      tick();
      chk("A_adr1", 64'(s_adr_o), 64'(adr_of(1)));
      s_rty_i = 1'b1;
      s_dat_i = 64'h5555_6666_7777_8888;
      pt(4'b0, 4'b0, 4'b0010, s_dat_i);
      tick();
      s_rty_i = 1'b0;
      setm(2'd1, 1'b0);
      tick();
      tick();

      // m0 burst of 4 while m1 waits
      m_cyc_i = 4'b0011;
      m_stb_i = 4'b0011;
      m_we_i  = 4'b0001;
      gq.push_back(4'b0001);
      tick();
      chk("B_we", 64'(s_we_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         s_ack_i = 1'b1;
         s_dat_i = 64'hB000 + 64'(i);
         pt(4'b0001, 4'b0, 4'b0, s_dat_i);
         tick();
         chk("B_hold", 64'(gnt_o), 64'b0001);
      end
      s_ack_i = 1'b0;
      m_we_i  = '0;
      setm(2'd0, 1'b0);
      gq.push_back(4'b0010);
      tick();
      tick();
      chk("B_adr1", 64'(s_adr_o), 64'(adr_of(1)));
      s_ack_i = 1'b1;
      s_dat_i = 64'hB1B1;
      pt(4'b0010, 4'b0, 4'b0, s_dat_i);
      tick();
      s_ack_i = 1'b0;
      setm(2'd1, 1'b0);
      tick();
      tick();

      // m1 stalls: err after 8 stalled cycles
      s_dat_i = '0;
      setm(2'd1, 1'b1);
      gq.push_back(4'b0010);
      pt(4'b0, 4'b0010, 4'b0, 64'd0);
      tick();
      for (int i = 0; i < TMO; i++) begin
         chk("C_noerr", 64'(m_err_o), 64'd0);
         tick();
      end
      chk("C_err", 64'(m_err_o), 64'b0010);
      chk("C_stb_supp", 64'(s_stb_o), 64'd0);
      chk("C_noack", 64'(m_ack_o), 64'd0);
      tick();
      chk("C_err_clr", 64'(m_err_o), 64'd0);
      chk("C_stb_back", 64'(s_stb_o), 64'd1);
      setm(2'd1, 1'b0);
      tick();
      tick();

      // ack lands on the timeout cycle
      setm(2'd0, 1'b1);
      gq.push_back(4'b0001);
      tick();
      for (int i = 0; i < TMO; i++) begin
         tick();
      end
      s_ack_i = 1'b1;
      s_dat_i = 64'hDDDD;
      pt(4'b0001, 4'b0, 4'b0, s_dat_i);
      #1;
      chk("D_noerr", 64'(m_err_o), 64'd0);
      chk("D_ack", 64'(m_ack_o), 64'b0001);
      chk("D_stb", 64'(s_stb_o), 64'd1);
      tick();
      s_ack_i = 1'b0;
      setm(2'd0, 1'b0);
      tick();
      tick();

      // reset mid-burst, then m0 wins
      m_cyc_i = 4'b0011;
      m_stb_i = 4'b0011;
      gq.push_back(4'b0010);
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 64'hE1;
      pt(4'b0010, 4'b0, 4'b0, s_dat_i);
      tick();
      s_ack_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("E_rst_cyc", 64'(s_cyc_o), 64'd0);
      chk("E_rst_stb", 64'(s_stb_o), 64'd0);
      chk("E_rst_gnt", 64'(gnt_o), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      gq.push_back(4'b0001);
      tick();
      chk("E_adr0", 64'(s_adr_o), 64'(adr_of(0)));
      m_cyc_i = '0;
      m_stb_i = '0;
      tick();
      tick();

      // four masters, continuous single xfers
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      m_cyc_i = 4'b1111;
      m_stb_i = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         e  = order[i];
         oh = 4'b0001 << e;
         gq.push_back(oh);
         tick();
         chk("F_adr", 64'(s_adr_o), 64'(adr_of(e)));
         s_ack_i = 1'b1;
         s_dat_i = 64'hF0 + 64'(i);
         pt(oh, 4'b0, 4'b0, s_dat_i);
         tick();
         s_ack_i = 1'b0;
         setm(2'(e), 1'b0);
         tick();
         setm(2'(e), 1'b1);
      end
      m_cyc_i = '0;
      m_stb_i = '0;
      tick();
      tick();
      tick();

      chk("tq_left", 64'(tq.size()), 64'd0);
      chk("gq_left", 64'(gq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2: number of Wishbone masters sharing one slave port (2..8).
REQ-002 SHALL have parameter DWIDTH, default 64: data width.
REQ-003 SHALL have parameter AWIDTH, default 32: address width.
REQ-004 SHALL have parameter SELWIDTH, default DWIDTH/8: byte-select width.
REQ-005 SHALL have parameter TIMEOUT, default 255: max wait cycles for a slave termination; 0 disables the watchdog.
REQ-006 SHALL have clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have m_cyc_i, m_stb_i, m_we_i, input, NUM_M each: per-master cycle, strobe and write-enable.
REQ-009 SHALL have m_adr_i, m_dat_i, m_sel_i, input, NUM_M*AWIDTH / NUM_M*DWIDTH / NUM_M*SELWIDTH: packed per-master address, write data and select; master k occupies slice k.
REQ-010 SHALL have m_dat_o, output, DWIDTH: read data broadcast to all masters.
REQ-011 SHALL have m_ack_o, m_err_o, m_rty_o, output, NUM_M each: per-master terminations.
REQ-012 SHALL have s_cyc_o, s_stb_o, s_we_o, output, 1 each; s_adr_o, s_dat_o, s_sel_o, output, AWIDTH/DWIDTH/SELWIDTH: slave-side request.
REQ-013 SHALL have s_dat_i, input, DWIDTH; s_ack_i, s_err_i, s_rty_i, input, 1 each: slave-side response.
REQ-014 SHALL have gnt_o, output, NUM_M: one-hot current grant, for debug.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 In IDLE with any m_cyc_i bit set, SHALL register a round-robin winner into gnt_o and enter BUSY on the next edge; search starts at index (last_gnt+1) mod NUM_M.
REQ-017 SHALL give a single request a one-cycle latency from m_cyc_i rising to s_cyc_o rising.
REQ-018 In BUSY, SHALL drive all s_* request outputs from the granted master's slice only; s_cyc_o = m_cyc_i[g], s_stb_o = m_cyc_i[g] & m_stb_i[g].
REQ-019 In IDLE, SHALL drive s_cyc_o, s_stb_o and s_we_o to 0, and s_adr_o, s_dat_o, s_sel_o to 0.
REQ-020 SHALL route s_ack_i, s_err_i and s_rty_i combinationally to the granted master only; non-granted m_*_o terminations SHALL be 0.
REQ-021 SHALL hold the grant for consecutive and burst transfers while m_cyc_i[g] stays high, irrespective of other requests.
REQ-022 When m_cyc_i[g] falls in BUSY, SHALL return to IDLE on that edge, record g as last_gnt and clear gnt_o; re-arbitration takes place in IDLE (one dead cycle between owners).
REQ-023 SHALL count cycles while s_stb_o=1 and no slave termination is present; the counter clears on any termination or when stb drops.
REQ-024 When the counter reaches TIMEOUT (TIMEOUT>0), SHALL pulse m_err_o[g] for exactly one cycle, suppress s_stb_o that cycle and clear the counter.
REQ-025 A slave termination arriving in the same cycle the counter reaches TIMEOUT SHALL take priority; no timeout error is generated.
REQ-026 The counter SHALL be width $clog2(TIMEOUT+1) and SHALL saturate, never wrap.
REQ-027 If several terminations assert together, SHALL forward all of them unchanged; the slave is responsible for the protocol violation.
REQ-028 m_dat_o SHALL equal s_dat_i at all times.

Reset
REQ-029 On rst_n low, SHALL asynchronously force state=IDLE, gnt_o=0, last_gnt=NUM_M-1 (master 0 wins first) and timeout counter=0.
REQ-030 Reset in the middle of a transfer SHALL drop s_cyc_o/s_stb_o immediately; no termination is sent to the interrupted master.

Structure
REQ-031 A shared package wshb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_BUSY) and default width constants.
REQ-032 The round-robin priority picker SHALL be a sub-module rr_pick, combinational, with inputs req[NUM_M] and last[$clog2(NUM_M)] and a one-hot output gnt[NUM_M].

Verification
REQ-033 Reset, then m_cyc_i=2'b11 -> gnt_o=01 after 1 cycle; when m0 drops cyc, one IDLE cycle, then gnt_o=10.
REQ-034 m0 holds cyc for a 4-beat burst while m1 requests -> four s_ack_i go to m_ack_o[0] only; m1 granted only after m0 releases.
REQ-035 Slave never acks, TIMEOUT=8 -> m_err_o[g] high for exactly one cycle after 8 stalled cycles; m_ack_o stays 0.
REQ-036 s_ack_i arrives on the exact cycle the counter reaches TIMEOUT -> ack is forwarded and m_err_o stays 0.
REQ-037 rst_n asserted mid-burst -> s_cyc_o=0 and gnt_o=0 in the same cycle; after release with m_cyc_i=2'b11, master 0 is granted.
REQ-038 NUM_M=4 with all masters requesting continuously and single transfers -> grant order 0,1,2,3,0.
